query_patch_loader: RTL
=======================

QUERY_PATCH_LOADER -- requirements
Module: query_patch_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 11, pixel width in bits.
REQ-002 SHALL have parameter PATCH_SIZE, default 5, pixels per patch; PW = DATA_WIDTH*PATCH_SIZE, legal range 33..64.
REQ-003 SHALL have parameter ADDR_WIDTH, default 9, patch memory address width.
REQ-004 SHALL have parameter DEPTH, default 512, patches in memory.
REQ-005 SHALL have parameter WB_ADDRESS_OFFSET, default 32'h3000_0000, byte base address of the Wishbone window.
REQ-006 SHALL have one clock and a synchronous, active-high reset: wb_clk_i  in  1  sole clock, all state on rising edge; wb_rst_i  in  1  reset.
REQ-007 SHALL have Wishbone slave ports: wbs_stb_i in 1; wbs_cyc_i in 1; wbs_we_i in 1; wbs_sel_i in 4 (ignored); wbs_dat_i in 32; wbs_adr_i in 32; wbs_ack_o out 1; wbs_dat_o out 32.
REQ-008 SHALL have wb_mode  in  1  1 = Wishbone owns memory port 0, 0 = engine owns it.
REQ-009 SHALL have engine ports: eng_csb0 in 1; eng_web0 in 1; eng_addr0 in ADDR_WIDTH; eng_wpatch0 in PW; eng_rpatch0 out PW.
REQ-010 SHALL have memory port-0 ports: mem_csb0 out 1; mem_web0 out 1; mem_addr0 out ADDR_WIDTH; mem_wpatch0 out PW; mem_rpatch0 in PW (valid one cycle after a read select).
REQ-011 SHALL have status ports: busy out 1 (state != IDLE); seq_err out 1 (sticky).

Function
REQ-012 SHALL decode off = wbs_adr_i - WB_ADDRESS_OFFSET; hit when wbs_cyc_i & wbs_stb_i & wb_mode & off < 8*DEPTH; patch address = off[ADDR_WIDTH+2:3]; half = off[2] (0 = low word, 1 = high word); off[1:0] ignored.
REQ-013 SHALL implement FSM states IDLE, WR_MEM, RD_MEM, RD_WAIT, ACK.
REQ-014 IDLE, no hit: remain IDLE, no memory access, no ack.
REQ-015 IDLE, hit, write, half=0: lo_buf <= wbs_dat_i, lo_addr <= patch address, lo_valid <= 1; go ACK (ack one cycle after acceptance); no memory access.
REQ-016 IDLE, hit, write, half=1: go WR_MEM; WR_MEM drives mem_csb0=0, mem_web0=0, mem_addr0=patch address, mem_wpatch0={wbs_dat_i[PW-33:0], lo_buf}; clear lo_valid; go ACK.
REQ-017 High-word write with lo_valid=0 or lo_addr != patch address: commit anyway with current lo_buf and set seq_err.
REQ-018 IDLE, hit, read: RD_MEM drives mem_csb0=0, mem_web0=1, mem_addr0; RD_WAIT captures mem_rpatch0; ACK presents captured data (ack three cycles after acceptance).
REQ-019 Read data: half=0 -> rpatch[31:0]; half=1 -> rpatch[PW-1:32] zero-extended to 32 bits.
REQ-020 ACK SHALL assert wbs_ack_o for exactly one cycle, then return to IDLE; IDLE SHALL not accept in the cycle ack is high.
REQ-021 wbs_dat_o SHALL be registered, hold its value outside ACK, and update only on reads.
REQ-022 wb_mode=0: mem_* = eng_* combinationally; FSM holds IDLE; no ack.
REQ-023 wb_mode=1 and FSM not in WR_MEM/RD_MEM: mem_csb0=1, mem_web0=1; eng_* ignored.
REQ-024 eng_rpatch0 = mem_rpatch0 at all times.
REQ-025 wb_mode falling mid-transaction: abort to IDLE next edge, no ack, no memory write unless already in WR_MEM that cycle; lo_valid kept.
REQ-026 wbs_cyc_i or wbs_stb_i dropping before ack: complete memory access, suppress ack, return IDLE.

Reset
REQ-027 wb_rst_i=1 at a rising edge SHALL force IDLE, wbs_ack_o=0, wbs_dat_o=0, lo_buf=0, lo_valid=0, seq_err=0, busy=0; mem_csb0/mem_web0 = 1 when wb_mode=1.
REQ-028 Reset mid-transaction SHALL abort without ack or memory write on the following cycle; only reset clears seq_err.

Verification
REQ-029 wb_mode=1: write 0xDEADBEEF @0x3000_0028, then 0x0012_3456 @0x3000_002C -> one mem write, addr 5, data {23'h123456, 32'hDEADBEEF}; acks at +1 and +2 cycles; seq_err=0.
REQ-030 Read 0x3000_0028 then 0x3000_002C after REQ-029 -> 0xDEADBEEF then 0x0012_3456, each acked 3 cycles after acceptance.
REQ-031 After reset, write high word @0x3000_0014 with no prior low -> mem write addr 2, low 32 bits 0; seq_err=1 until reset.
REQ-032 wb_mode=0, eng_csb0=0, eng_web0=0, eng_addr0=7 -> mem port mirrors engine same cycle; Wishbone write @0x3000_0000 never acked.
REQ-033 Access @0x3000_1000 (off = 8*DEPTH) -> no ack, no memory access; @0x3000_0FFC -> hit, addr 511, half 1.
REQ-034 Assert wb_rst_i in RD_WAIT -> no ack, IDLE next cycle, wbs_dat_o=0.

Source files
------------

// File: rtl/query_patch_loader.sv
// Wishbone-to-patch-memory bridge: assembles two 32-bit Wishbone words into one
// wide patch and arbitrates memory port 0 between the bus and the matching engine.
module query_patch_loader #(
  parameter int          DATA_WIDTH        = 11,
  parameter int          PATCH_SIZE        = 5,
  parameter int          ADDR_WIDTH        = 9,
  parameter int          DEPTH             = 512,
  parameter logic [31:0] WB_ADDRESS_OFFSET = 32'h3000_0000
) (
  input  logic                                wb_clk_i,
  input  logic                                wb_rst_i,
  input  logic                                wbs_stb_i,
  input  logic                                wbs_cyc_i,
  input  logic                                wbs_we_i,
  input  logic [3:0]                          wbs_sel_i,
  input  logic [31:0]                         wbs_dat_i,
  input  logic [31:0]                         wbs_adr_i,
  output logic                                wbs_ack_o,
  output logic [31:0]                         wbs_dat_o,
  input  logic                                wb_mode,
  input  logic                                eng_csb0,
  input  logic                                eng_web0,
  input  logic [ADDR_WIDTH-1:0]               eng_addr0,
  input  logic [DATA_WIDTH*PATCH_SIZE-1:0]    eng_wpatch0,
  output logic [DATA_WIDTH*PATCH_SIZE-1:0]    eng_rpatch0,
  output logic                                mem_csb0,
  output logic                                mem_web0,
  output logic [ADDR_WIDTH-1:0]               mem_addr0,
  output logic [DATA_WIDTH*PATCH_SIZE-1:0]    mem_wpatch0,
  input  logic [DATA_WIDTH*PATCH_SIZE-1:0]    mem_rpatch0,
  output logic                                busy,
  output logic                                seq_err
);

  localparam int          PW        = DATA_WIDTH * PATCH_SIZE;
  localparam logic [31:0] WIN_BYTES = 32'(8 * DEPTH);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_MEM  = 3'd1,
    RD_MEM  = 3'd2,
    RD_WAIT = 3'd3,
    ACK     = 3'd4
  } state_t;

  state_t                state_r, state_next_s;
  logic [31:0]           off_s;
  logic                  hit_s, xfer_s, half_s;
  logic [ADDR_WIDTH-1:0] req_addr_s, req_addr_r, lo_addr_r;
  logic                  req_half_r, lo_valid_r, seq_err_r, ack_r, busy_r;
  logic [PW-33:0]        wdata_r;
  logic [31:0]           lo_buf_r, dat_r, rd_word_s;
  logic                  unused_s;

  // Address decode of the Wishbone window
  always_comb begin
    off_s      = wbs_adr_i - WB_ADDRESS_OFFSET;
    xfer_s     = wbs_cyc_i & wbs_stb_i;
    hit_s      = xfer_s & wb_mode & (off_s < WIN_BYTES);
    req_addr_s = off_s[ADDR_WIDTH+2:3];
    half_s     = off_s[2];
  end

  assign unused_s = ^{wbs_sel_i, off_s[1:0]};

  // State register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; losing wb_mode aborts, a dropped strobe still finishes the access
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (hit_s) begin
          if (!wbs_we_i) begin
            state_next_s = RD_MEM;
          end else if (half_s) begin
            state_next_s = WR_MEM;
          end else begin
            state_next_s = ACK;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      WR_MEM:  state_next_s = (wb_mode && xfer_s) ? ACK : IDLE;
      RD_MEM:  state_next_s = (wb_mode && xfer_s) ? RD_WAIT : IDLE;
      RD_WAIT: state_next_s = (wb_mode && xfer_s) ? ACK : IDLE;
      ACK:     state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Select the requested 32-bit half of the returned patch
  always_comb begin
    rd_word_s = 32'd0;
    if (req_half_r) begin
      rd_word_s[PW-33:0] = mem_rpatch0[PW-1:32];
    end else begin
      rd_word_s = mem_rpatch0[31:0];
    end
  end

  // Request capture, low-word buffer, sequencing error and registered bus outputs
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      req_addr_r <= '0;
      req_half_r <= 1'b0;
      wdata_r    <= '0;
      lo_buf_r   <= 32'd0;
      lo_addr_r  <= '0;
      lo_valid_r <= 1'b0;
      seq_err_r  <= 1'b0;
      ack_r      <= 1'b0;
      busy_r     <= 1'b0;
      dat_r      <= 32'd0;
    end else begin
      ack_r  <= (state_next_s == ACK);
      busy_r <= (state_next_s != IDLE);
      if (state_r == IDLE && hit_s) begin
        req_addr_r <= req_addr_s;
        req_half_r <= half_s;
        wdata_r    <= wbs_dat_i[PW-33:0];
        if (wbs_we_i && !half_s) begin
          lo_buf_r   <= wbs_dat_i;
          lo_addr_r  <= req_addr_s;
          lo_valid_r <= 1'b1;
        end
      end
      // The high word commits whatever low word is buffered; a stale one is flagged
      if (state_r == WR_MEM && wb_mode) begin
        lo_valid_r <= 1'b0;
        if (!lo_valid_r || lo_addr_r != req_addr_r) begin
          seq_err_r <= 1'b1;
        end
      end
      if (state_r == RD_WAIT && state_next_s == ACK) begin
        dat_r <= rd_word_s;
      end
    end
  end

  // Memory port 0 ownership
  always_comb begin
    mem_csb0    = 1'b1;
    mem_web0    = 1'b1;
    mem_addr0   = req_addr_r;
    mem_wpatch0 = {wdata_r, lo_buf_r};
    if (!wb_mode) begin
      mem_csb0    = eng_csb0;
      mem_web0    = eng_web0;
      mem_addr0   = eng_addr0;
      mem_wpatch0 = eng_wpatch0;
    end else if (state_r == WR_MEM) begin
      mem_csb0 = 1'b0;
      mem_web0 = 1'b0;
    end else if (state_r == RD_MEM) begin
      mem_csb0 = 1'b0;
      mem_web0 = 1'b1;
    end else begin
      mem_csb0 = 1'b1;
      mem_web0 = 1'b1;
    end
  end

  assign eng_rpatch0 = mem_rpatch0;
  assign wbs_ack_o   = ack_r;
  assign wbs_dat_o   = dat_r;
  assign busy        = busy_r;
  assign seq_err     = seq_err_r;

endmodule
